// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
// Request field widths follow the package defaults used by the top.
package mem_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

    typedef struct packed {
        logic                  we;
        logic [DW_DEF/8-1:0]   be;
        logic [AW_DEF-1:0]     addr;
        logic [DW_DEF-1:0]     wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bus between the arbiter (master) and the memory wrapper (slave).
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [DW/8-1:0]   mem_be;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_rsp_valid;
    logic [DW-1:0]     mem_rdata;

    modport master (
        output mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter_prio.sv
// Winner select between fetch and data, with the fetch-starvation counter.
module mem_arb_prio
    import mem_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       if_req,
    input  logic       d_req,
    input  logic       grant,
    output arb_owner_e winner
);
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic       fetch_forced;

    assign fetch_forced = if_req && (wait_cnt == WAIT_LIM);
    assign winner       = (d_req && !fetch_forced) ? OWN_D : OWN_IF;

    // Counts data grants that overtook a waiting fetch; any gap in if_req forgives the debt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (!if_req) begin
            wait_cnt <= '0;
        end else if (grant) begin
            if (winner == OWN_IF) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIM) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises IF-stage fetches and MEM-stage loads/stores onto one single-ported memory.
// state | meaning
// IDLE  | no transaction; arbitrate and latch winner's request
// REQ   | mem_req_valid high, fields held until mem_req_ready
// RESP  | waiting for mem_rsp_valid; routed to the owner that cycle
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_req,
    input  logic [AW-1:0]           if_addr,
    output logic                    if_rsp_valid,
    output logic [DW-1:0]           if_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DW/8-1:0]         d_be,
    input  logic [AW-1:0]           d_addr,
    input  logic [DW-1:0]           d_wdata,
    output logic                    d_rsp_valid,
    output logic [DW-1:0]           d_rdata,
    output logic                    stall_if,
    output logic                    stall_mem,
    mem_port_arbiter_if.master      mem
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_REQ  = REQ;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0] state;
    arb_owner_e owner_q;
    arb_owner_e winner;
    mem_req_t   req_q;
    logic       grant;
    logic       rsp_fire;

    assign grant = (state == ST_IDLE) && (if_req || d_req);

    mem_arb_prio #(.MAX_WAIT(MAX_WAIT)) u_prio (
        .clk    (clk),
        .rst_n  (rst_n),
        .if_req (if_req),
        .d_req  (d_req),
        .grant  (grant),
        .winner (winner)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            owner_q <= OWN_IF;
            req_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state   <= ST_REQ;
                        owner_q <= winner;
                        if (winner == OWN_D) begin
                            req_q <= '{we: d_we, be: d_be, addr: d_addr, wdata: d_wdata};
                        end else begin
                            req_q <= '{we: 1'b0, be: '1, addr: if_addr, wdata: '0};
                        end
                    end
                end
                ST_REQ: begin
                    if (mem.mem_req_ready) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem.mem_rsp_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem.mem_req_valid = (state == ST_REQ);
    assign mem.mem_we        = req_q.we;
    assign mem.mem_be        = req_q.be;
    assign mem.mem_addr      = req_q.addr;
    assign mem.mem_wdata     = req_q.wdata;

    // A requester that dropped its req was flushed; its response is swallowed.
    assign rsp_fire     = (state == ST_RESP) && mem.mem_rsp_valid;
    assign if_rsp_valid = rsp_fire && (owner_q == OWN_IF) && if_req;
    assign d_rsp_valid  = rsp_fire && (owner_q == OWN_D) && d_req;
    assign if_rdata     = if_rsp_valid ? mem.mem_rdata : '0;
    assign d_rdata      = (d_rsp_valid && !req_q.we) ? mem.mem_rdata : '0;

    assign stall_if  = if_req && !if_rsp_valid;
    assign stall_mem = d_req && !d_rsp_valid;

    a_rsp_only_in_resp: assert property (
        @(posedge clk) disable iff (!rst_n) mem.mem_rsp_valid |-> (state == ST_RESP)
    ) else $warning("mem_rsp_valid outside RESP ignored");

endmodule
